// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache with multi-word blocks and
// per-set round-robin replacement. Hits are combinational; a miss fills the
// whole block with BLOCK_WORDS sequential word reads. flush invalidates every
// line in one cycle and aborts any fill in progress.
//
// Ports:
//   CLK, nRST             clock (rising edge), async active-low reset
//   imemREN, imemaddr     fetch request and byte address
//   flush                 invalidate all lines, reset all victim pointers
//   ihit, imemload        requested word valid / fetched instruction
//   mem_iREN, mem_iaddr   memory read request / word-aligned address
//   mem_iwait, mem_iload  memory busy / read data
module icache_assoc #(
  parameter int unsigned WAYS        = 2,
  parameter int unsigned SETS        = 8,
  parameter int unsigned BLOCK_WORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        mem_iREN,
  output logic [31:0] mem_iaddr,
  input  logic        mem_iwait,
  input  logic [31:0] mem_iload
);

  localparam int unsigned WOB = $clog2(BLOCK_WORDS);
  localparam int unsigned CW  = (WOB > 0) ? WOB : 1;
  localparam int unsigned IB  = $clog2(SETS);
  localparam int unsigned PW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned TW  = 32 - 2 - WOB - IB;

  typedef enum logic {StIdle, StFill} state_t;

  logic            r_valid [WAYS][SETS];
  logic [TW-1:0]   r_tag   [WAYS][SETS];
  logic [31:0]     r_data  [WAYS][SETS][BLOCK_WORDS];
  logic [PW-1:0]   r_ptr   [SETS];

  state_t          r_state, w_state_next;
  logic [31:0]     r_base;
  logic [PW-1:0]   r_victim;
  logic [CW-1:0]   r_cnt;

  logic [IB-1:0]   w_idx, w_bidx;
  logic [TW-1:0]   w_tag, w_btag;
  logic [CW-1:0]   w_woff;
  logic            w_hit;
  logic [PW-1:0]   w_hway;
  logic            w_miss, w_accept, w_last;

  // Address decode for the lookup and for the latched fill base.
  assign w_idx  = IB'(imemaddr >> (2 + WOB));
  assign w_tag  = TW'(imemaddr >> (2 + WOB + IB));
  assign w_woff = CW'((imemaddr >> 2) & 32'(BLOCK_WORDS - 1));
  assign w_bidx = IB'(r_base >> (2 + WOB));
  assign w_btag = TW'(r_base >> (2 + WOB + IB));

  always_comb begin
    w_hit  = 1'b0;
    w_hway = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
        w_hit  = 1'b1;
        w_hway = PW'(w);
      end
    end
  end

  assign w_miss   = (r_state == StIdle) && imemREN && !w_hit;
  assign w_accept = (r_state == StFill) && !mem_iwait;
  assign w_last   = (r_cnt == CW'(BLOCK_WORDS - 1));

  always_comb begin
    w_state_next = r_state;
    ihit         = 1'b0;
    imemload     = '0;
    mem_iREN     = 1'b0;
    mem_iaddr    = '0;
    unique case (r_state)
      StIdle: begin
        ihit = imemREN && w_hit;
        if (ihit) imemload = r_data[w_hway][w_idx][w_woff];
        if (w_miss) w_state_next = StFill;
      end
      StFill: begin
        mem_iREN  = 1'b1;
        mem_iaddr = r_base + (32'(r_cnt) << 2);
        if (w_accept && w_last) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
    // mem_iREN is left alone here: it drops the cycle after flush.
    if (flush) begin
      w_state_next = StIdle;
      ihit         = 1'b0;
      imemload     = '0;
    end
  end

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      r_state  <= StIdle;
      r_base   <= '0;
      r_victim <= '0;
      r_cnt    <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_ptr[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_valid[w][s] <= 1'b0;
      end
    end else begin
      r_state <= w_state_next;
      if (flush) begin
        for (int s = 0; s < SETS; s++) begin
          r_ptr[s] <= '0;
          for (int w = 0; w < WAYS; w++) r_valid[w][s] <= 1'b0;
        end
      end else if (w_miss) begin
        // Victim is invalidated up front so an aborted fill leaves no stale line.
        r_base                     <= imemaddr & ~32'(BLOCK_WORDS * 4 - 1);
        r_victim                   <= r_ptr[w_idx];
        r_cnt                      <= '0;
        r_valid[r_ptr[w_idx]][w_idx] <= 1'b0;
      end else if (w_accept) begin
        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        if (w_last) begin
          r_valid[r_victim][w_bidx] <= 1'b1;
          r_ptr[w_bidx]             <= (WAYS > 1) ? r_ptr[w_bidx] + 1'b1 : '0;
        end
      end
    end
  end

  // Data and tag arrays carry no reset; valid bits guard them.
  always_ff @(posedge CLK) begin
    if (w_accept && !flush) begin
      r_data[r_victim][w_bidx][r_cnt] <= mem_iload;
      if (w_last) r_tag[r_victim][w_bidx] <= w_btag;
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc with default parameters
// (WAYS=2, SETS=8, BLOCK_WORDS=2).
module tb_icache_assoc;

  localparam int BW = 2;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        mem_iREN;
  logic [31:0] mem_iaddr;
  logic        mem_iwait;
  logic [31:0] mem_iload;

  int n_chk = 0;
  int n_err = 0;
  int wait_cfg = 0;
  int wctr = 0;
  logic [31:0] exp_q[$];

  icache_assoc #(.WAYS(2), .SETS(8), .BLOCK_WORDS(2)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .flush     (flush),
    .ihit      (ihit),
    .imemload  (imemload),
    .mem_iREN  (mem_iREN),
    .mem_iaddr (mem_iaddr),
    .mem_iwait (mem_iwait),
    .mem_iload (mem_iload)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Memory contents: [0x40]=0xAAAA0001, [0x44]=0xAAAA0002, and so on.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hAAAA0000 + (a >> 2) - 32'd15;
  endfunction

  assign mem_iload = memf(mem_iaddr);
  assign mem_iwait = mem_iREN && (wctr < wait_cfg);

  // wait_cfg busy cycles before every accepted word.
  always @(posedge CLK) begin
    if (!mem_iREN || !mem_iwait) wctr <= 0;
    else wctr <= wctr + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted memory read must match the next queued address.
  always @(negedge CLK) begin
    if (nRST && mem_iREN && !mem_iwait) begin
      if (exp_q.size() == 0) chk("sb_unexpected_read", mem_iaddr, 32'hDEADBEEF);
      else chk("sb_read_addr", mem_iaddr, exp_q.pop_front());
    end
  end

  // Miss on a, fill with `waits` busy cycles per word, expect hit at cycle exp_cyc.
  task automatic fill(input logic [31:0] a, input int waits, input int exp_cyc);
    logic [31:0] base;
    int cyc;
    bit done;
    base = a & ~32'(BW * 4 - 1);
    wait_cfg = waits;
    for (int i = 0; i < BW; i++) exp_q.push_back(base + 32'(4 * i));
    imemaddr = a;
    imemREN  = 1'b1;
    #1;
    chk("fill_initial_miss", 32'(ihit), 32'd0);
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 64) begin
      @(negedge CLK);
      cyc++;
      if (ihit) done = 1'b1;
      else begin
        chk("fill_ren", 32'(mem_iREN), 32'd1);
        chk("fill_addr", mem_iaddr, base + 32'(4 * ((cyc - 1) / (waits + 1))));
      end
    end
    chk("fill_latency", 32'(cyc), 32'(exp_cyc));
    chk("fill_data", imemload, memf(a & ~32'h3));
    chk("fill_idle_ren", 32'(mem_iREN), 32'd0);
    imemREN  = 1'b0;
    wait_cfg = 0;
    @(negedge CLK);
  endtask

  typedef struct {
    int          phase;
    logic        ren;
    logic [31:0] addr;
    logic        hit;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[15];

  task automatic run_phase(input int p);
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].phase == p) begin
        imemREN  = vecs[i].ren;
        imemaddr = vecs[i].addr;
        #1;
        chk($sformatf("vec%0d_hit", i), 32'(ihit), 32'(vecs[i].hit));
        chk($sformatf("vec%0d_data", i), imemload, vecs[i].data);
        imemREN = 1'b0;
        @(negedge CLK);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{0, 1'b1, 32'h40, 1'b1, 32'hAAAA0001};
    vecs[1]  = '{0, 1'b1, 32'h44, 1'b1, 32'hAAAA0002};
    vecs[2]  = '{0, 1'b1, 32'h80, 1'b1, memf(32'h80)};
    vecs[3]  = '{0, 1'b1, 32'h86, 1'b1, memf(32'h84)};
    vecs[4]  = '{0, 1'b1, 32'hC0, 1'b0, 32'h0};
    vecs[5]  = '{0, 1'b0, 32'h40, 1'b0, 32'h0};
    vecs[6]  = '{0, 1'b1, 32'h48, 1'b0, 32'h0};
    vecs[7]  = '{1, 1'b1, 32'h80, 1'b1, memf(32'h80)};
    vecs[8]  = '{1, 1'b1, 32'h84, 1'b1, memf(32'h84)};
    vecs[9]  = '{1, 1'b1, 32'hC0, 1'b1, memf(32'hC0)};
    vecs[10] = '{1, 1'b1, 32'hC4, 1'b1, memf(32'hC4)};
    vecs[11] = '{1, 1'b1, 32'h40, 1'b0, 32'h0};
    vecs[12] = '{2, 1'b1, 32'h80, 1'b0, 32'h0};
    vecs[13] = '{2, 1'b1, 32'h44, 1'b1, 32'hAAAA0002};
    vecs[14] = '{2, 1'b1, 32'hC4, 1'b1, memf(32'hC4)};

    nRST     = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    flush    = 1'b0;
    @(negedge CLK);
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_mem_iREN", 32'(mem_iREN), 32'd0);
    chk("rst_mem_iaddr", mem_iaddr, 32'd0);
    imemREN = 1'b0;
    nRST    = 1'b1;
    @(negedge CLK);

    // Cold miss, then same-cycle hit on the other word of the block.
    fill(32'h40, 0, 3);
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    #1;
    chk("t1_hit_w0", imemload, 32'hAAAA0001);
    imemaddr = 32'h44;
    #1;
    chk("t1_hit_w1", 32'(ihit), 32'd1);
    chk("t1_data_w1", imemload, 32'hAAAA0002);

    // Flush: ihit forced low while flush is high, line gone afterwards.
    imemaddr = 32'h40;
    flush    = 1'b1;
    #1;
    chk("t4_flush_ihit", 32'(ihit), 32'd0);
    @(negedge CLK);
    flush = 1'b0;
    #1;
    chk("t4_after_flush_miss", 32'(ihit), 32'd0);
    chk("t4_after_flush_noren", 32'(mem_iREN), 32'd0);
    imemREN = 1'b0;
    @(negedge CLK);

    // Conflict and round-robin in set 0.
    fill(32'h40, 0, 3);
    fill(32'h80, 0, 3);
    run_phase(0);
    fill(32'hC0, 0, 3);
    run_phase(1);
    fill(32'h40, 0, 3);
    run_phase(2);

    // Wait states: 3 busy cycles per word.
    fill(32'h100, 3, 9);

    // Flush during the first fill cycle.
    exp_q.push_back(32'h200);
    imemREN  = 1'b1;
    imemaddr = 32'h200;
    @(negedge CLK);
    chk("t4b_fill_started", 32'(mem_iREN), 32'd1);
    flush   = 1'b1;
    imemREN = 1'b0;
    @(negedge CLK);
    flush = 1'b0;
    chk("t4b_ren_dropped", 32'(mem_iREN), 32'd0);
    chk("t4b_addr_zero", mem_iaddr, 32'd0);
    imemREN  = 1'b1;
    imemaddr = 32'h200;
    #1;
    chk("t4b_line_invalid", 32'(ihit), 32'd0);
    imemREN = 1'b0;
    @(negedge CLK);
    fill(32'h200, 0, 3);

    // No request.
    for (int i = 0; i < 20; i++) begin
      imemaddr = $urandom();
      #1;
      chk("t5_no_ren", 32'(mem_iREN), 32'd0);
      chk("t5_no_hit", 32'(ihit), 32'd0);
      @(negedge CLK);
    end

    // Reset mid-fill.
    fill(32'h40, 0, 3);
    wait_cfg = 3;
    imemREN  = 1'b1;
    imemaddr = 32'h300;
    @(negedge CLK);
    chk("t6_in_fill", 32'(mem_iREN), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("t6_rst_ihit", 32'(ihit), 32'd0);
    chk("t6_rst_imemload", imemload, 32'd0);
    chk("t6_rst_ren", 32'(mem_iREN), 32'd0);
    chk("t6_rst_addr", mem_iaddr, 32'd0);
    exp_q.delete();
    imemREN  = 1'b0;
    wait_cfg = 0;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    #1;
    chk("t6_post_rst_miss", 32'(ihit), 32'd0);
    imemREN = 1'b0;
    @(negedge CLK);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised set-associative instruction cache with multi-word blocks and round-robin replacement. It sits between the datapath fetch port and the memory controller's instruction channel, in the same position as the current direct-mapped icache. Hits return data in the same cycle. A miss triggers a block fill of BLOCK_WORDS sequential word reads, and a flush input clears the whole cache in one cycle.

## Interface
- WAYS, 2: associativity; power of 2, 1..4
- SETS, 8: sets per way; power of 2, ≥2
- BLOCK_WORDS, 2: 32-bit words per block; power of 2, 1..8
- Address split (byte address): bits [1:0] byte offset (ignored); next log2(BLOCK_WORDS) bits are the word offset; next log2(SETS) bits are the index; the remaining upper bits are the tag.

- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  fetch byte address
- flush  in  1  invalidate all lines (single-cycle pulse)
- ihit  out  1  requested word valid on imemload this cycle
- imemload  out  32  fetched instruction
- mem_iREN  out  1  memory read request
- mem_iaddr  out  32  memory read address, word aligned
- mem_iwait  in  1  memory busy; the word is accepted on the first cycle it is low
- mem_iload  in  32  memory read data

## Operation
- Storage per line: valid bit, tag, BLOCK_WORDS data words. Storage per set: one round-robin victim pointer, log2(WAYS) bits, or nothing when WAYS=1.
- FSM has two states: IDLE and FILL.
- IDLE:
  - ihit = imemREN & (some way in the indexed set is valid with a matching tag).
  - imemload = the word at the word offset of the matching way; 0 when ihit=0.
  - On imemREN & miss, the next state is FILL. At that edge the block latches:
    - base address = imemaddr with word and byte offset cleared
    - victim way = the set's round-robin pointer
    - word counter = 0
    - the victim line's valid bit is cleared
- FILL:
  - ihit=0 and imemload=0.
  - mem_iREN=1 and mem_iaddr = base + 4*counter.
  - When mem_iwait=0, mem_iload is written to the victim at word [counter], and the counter increments.
  - On acceptance of the last word (counter = BLOCK_WORDS-1):
    - tag is written and valid set to 1
    - the set's pointer advances by 1 mod WAYS
    - the next state is IDLE
  - imemaddr and imemREN are ignored during FILL. The fill always completes for the latched base.
- mem_iREN=0 and mem_iaddr=0 whenever the state is not FILL.
- Flush takes priority over everything:
  - All valid bits and all pointers are cleared at the next edge, and the state goes to IDLE.
  - A fill in progress is aborted: the partially filled line stays invalid, and mem_iREN drops the cycle after flush.
  - While flush is high, ihit is forced to 0.
- Victim choice ignores the valid bits. This is pure round-robin per set, and it is deterministic for verification.

## Timing
- Hits have zero latency: ihit and imemload are combinational from imemaddr and the stored state.
- Miss cycle count with no wait states:
  - Request in IDLE at cycle 0.
  - FILL runs in cycles 1..BLOCK_WORDS.
  - IDLE returns at cycle BLOCK_WORDS+1, with ihit=1 if imemREN and imemaddr are unchanged.
- Each wait cycle extends FILL by one cycle. mem_iaddr holds stable while mem_iwait=1.
- Reset is asynchronous and may arrive mid-fill. Reset values:
  - state IDLE, all valid bits 0, all pointers 0, counter 0
  - ihit 0, imemload 0, mem_iREN 0, mem_iaddr 0
- flush and a miss in the same IDLE cycle: flush wins, no fill starts, and the miss re-evaluates next cycle.
- The last-word write and the hit lookup never coincide, because the lookup only happens in IDLE.

## Test plan
Defaults: WAYS=2, SETS=8, BLOCK_WORDS=2, so index = addr[5:3].
1. Cold miss:
   - Stimulus: after reset, imemREN=1, imemaddr=0x40, mem_iwait=0, memory holds [0x40]=0xAAAA0001 and [0x44]=0xAAAA0002.
   - Required: mem_iaddr is 0x40 in cycle 1 and 0x44 in cycle 2.
   - Required: ihit=1 with imemload=0xAAAA0001 in cycle 3.
   - Required: switching imemaddr to 0x44 then gives ihit=1 the same cycle with 0xAAAA0002.
2. Conflict and round-robin:
   - Stimulus: fill 0x40 then 0x80; both then hit. Fetch 0xC0 (index 0, tag 3).
   - Required: 0xC0 evicts way 0, which holds 0x40.
   - Required: afterwards 0x80 hits and 0x40 misses; refilling 0x40 evicts way 1 (0x80).
3. Wait states:
   - Stimulus: miss on 0x100 with mem_iwait high for 3 cycles before each word.
   - Required: mem_iaddr holds 0x100 for 4 cycles, then 0x104 for 4 cycles.
   - Required: ihit first asserts at cycle 9.
4. Flush:
   - Stimulus: after test 1, pulse flush.
   - Required: 0x40 misses next cycle.
   - Stimulus: pulse flush during cycle 1 of a fill.
   - Required: mem_iREN=0 in the next cycle, the state is IDLE, and the line is invalid.
5. No request:
   - Stimulus: imemREN=0 with a random imemaddr for 20 cycles.
   - Required: mem_iREN stays 0 and ihit stays 0.
6. Reset mid-fill:
   - Stimulus: assert nRST low asynchronously while mem_iREN=1.
   - Required: all outputs read 0 immediately.
   - Required: after release, the previously cached 0x40 misses.
